seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 105 ++++++++++
 tb/tb_seq_divider.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential restoring divider: unsigned XLEN/XLEN -> quotient, remainder.
// One quotient bit is resolved per OPERATE cycle; a zero divisor short-cuts
// straight to DONE with an all-ones quotient and the dividend as remainder.
module seq_divider #(
  parameter int XLEN = 16
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            ack_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o,
  output logic            div_by_zero_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] OPERATE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  logic [1:0]      state;
  logic [XLEN-1:0] dvd_q;   // dividend, shifted out MSB-first
  logic [XLEN-1:0] dvs_q;   // captured divisor
  logic [XLEN-1:0] rem_q;   // partial remainder, always < divisor
  logic [XLEN-1:0] quo_q;   // quotient, built LSB-in
  logic [CW-1:0]   cnt_q;
  logic            dbz_q;

  // One restoring step; the shifted value needs XLEN+1 bits, but whenever
  // it is >= divisor the difference is < divisor, so XLEN bits suffice.
  logic [XLEN:0]   shifted;
  logic            ge;
  logic [XLEN-1:0] diff;
  logic [XLEN-1:0] rem_next;

  // Datapath step for the current OPERATE cycle
  always_comb begin
    shifted  = {rem_q, dvd_q[XLEN-1]};
    ge       = (shifted >= {1'b0, dvs_q});
    diff     = shifted[XLEN-1:0] - dvs_q;
    rem_next = ge ? diff : shifted[XLEN-1:0];
  end

  // Control FSM and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      dvd_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            dvd_q <= dividend_i;
            dvs_q <= divisor_i;
            cnt_q <= '0;
            if (divisor_i == '0) begin
              quo_q <= '1;
              rem_q <= dividend_i;
              dbz_q <= 1'b1;
              state <= DONE;
            end else begin
              quo_q <= '0;
              rem_q <= '0;
              dbz_q <= 1'b0;
              state <= OPERATE;
            end
          end
        end
        OPERATE: begin
          rem_q <= rem_next;
          quo_q <= {quo_q[XLEN-2:0], ge};
          dvd_q <= {dvd_q[XLEN-2:0], 1'b0};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) state <= DONE;
        end
        DONE: begin
          // start_i is deliberately not looked at here, even alongside ack
          if (ack_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Results are only visible while DONE
  always_comb begin
    busy_o        = (state == OPERATE);
    done_o        = (state == DONE);
    quotient_o    = done_o ? quo_q : '0;
    remainder_o   = done_o ? rem_q : '0;
    div_by_zero_o = done_o & dbz_q;
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (XLEN=16): directed operations push their
// expected result; a monitor pops and compares on each rising done_o.
module tb_seq_divider;
  localparam int XLEN = 16;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            start_i = 1'b0;
  logic [XLEN-1:0] dividend_i = '0;
  logic [XLEN-1:0] divisor_i = '0;
  logic            ack_i = 1'b0;
  logic            busy_o, done_o, div_by_zero_o;
  logic [XLEN-1:0] quotient_o, remainder_o;

  seq_divider #(.XLEN(XLEN)) dut (
    .clk(clk), .resetn(resetn), .start_i(start_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .ack_i(ack_i),
    .busy_o(busy_o), .done_o(done_o), .quotient_o(quotient_o),
    .remainder_o(remainder_o), .div_by_zero_o(div_by_zero_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [XLEN-1:0] q;
    logic [XLEN-1:0] r;
    logic            dbz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Monitor: compare the scoreboard head on every rising edge of done_o
  always @(negedge clk) begin
    if (done_o && !prev_done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done_o=1 q=%0d r=%0d, expected no result", quotient_o, remainder_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", 64'(quotient_o), 64'(e.q));
        chk("remainder", 64'(remainder_o), 64'(e.r));
        chk("div_by_zero", 64'(div_by_zero_o), 64'(e.dbz));
      end
    end
    prev_done = done_o;
  end

  // Present a start for one cycle; returns on the negedge after acceptance
  task automatic drive_start(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    @(negedge clk);
    start_i = 1'b1; dividend_i = a; divisor_i = b;
    @(negedge clk);
    start_i = 1'b0; dividend_i = 16'h5A5A; divisor_i = 16'h0000;
  endtask

  task automatic issue(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] q, input logic [XLEN-1:0] r, input logic dbz);
    exp_t e;
    e.q = q; e.r = r; e.dbz = dbz;
    sb.push_back(e);
    drive_start(a, b);
  endtask

  // Called on the first negedge after acceptance; lat counts edges from
  // the accepting edge (inclusive) to the one that raises done_o
  task automatic wait_done(input int exp_lat, input int exp_busy);
    int lat = 1;
    int nb = 0;
    if (busy_o) nb++;
    while (!done_o && lat < 200) begin
      @(negedge clk);
      lat++;
      if (busy_o) nb++;
    end
    if (!done_o) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done_o after %0d cycles, expected done_o", lat);
    end else if (exp_lat > 0) begin
      chk("latency", 64'(lat), 64'(exp_lat));
      chk("busy_cycles", 64'(nb), 64'(exp_busy));
    end
  endtask

  task automatic ack_and_check();
    ack_i = 1'b1;
    @(negedge clk);
    ack_i = 1'b0;
    chk("idle_done", 64'(done_o), 64'd0);
    chk("idle_outs", {31'd0, busy_o, quotient_o, remainder_o, div_by_zero_o}, 64'd0);
  endtask

  initial begin
    logic [XLEN-1:0] hq, hr;

    // Reset
    repeat (2) @(negedge clk);
    chk("reset_outs", {29'd0, busy_o, done_o, quotient_o, remainder_o, div_by_zero_o}, 64'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_reset_outs", {29'd0, busy_o, done_o, quotient_o, remainder_o, div_by_zero_o}, 64'd0);

    // 100/7: 16 busy cycles, done on the 17th edge
    issue(16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
    wait_done(17, 16);
    ack_and_check();

    // Boundary operands
    issue(16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0);
    wait_done(17, 16);
    ack_and_check();
    issue(16'h0003, 16'h000A, 16'h0000, 16'h0003, 1'b0);
    wait_done(17, 16);
    ack_and_check();
    issue(16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0);
    wait_done(17, 16);
    ack_and_check();

    // Divide by zero: one edge, then hold without ack
    issue(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1);
    wait_done(1, 0);
    hq = quotient_o; hr = remainder_o;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_done", {62'd0, done_o, div_by_zero_o}, 64'd3);
      chk("hold_q", 64'(quotient_o), 64'(hq));
      chk("hold_r", 64'(remainder_o), 64'(hr));
    end
    ack_and_check();

    // Start pulse and operand changes mid-operation are ignored
    issue(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0);
    repeat (3) @(negedge clk);
    start_i = 1'b1; dividend_i = 16'd50; divisor_i = 16'd5;
    @(negedge clk);
    start_i = 1'b0; dividend_i = 16'hAAAA; divisor_i = 16'h0001;
    wait_done(0, 0);
    ack_and_check();

    // Reset mid-operation aborts without a done pulse
    drive_start(16'd1000, 16'd3);
    repeat (7) @(negedge clk);
    chk("pre_abort_busy", 64'(busy_o), 64'd1);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("abort_outs", {29'd0, busy_o, done_o, quotient_o, remainder_o, div_by_zero_o}, 64'd0);
    repeat (20) @(negedge clk);
    chk("abort_no_done", 64'(done_o), 64'd0);
    issue(16'd9, 16'd2, 16'd4, 16'd1, 1'b0);
    wait_done(17, 16);
    ack_and_check();

    // ack and start together in DONE: ack wins, no new operation
    issue(16'd7, 16'd2, 16'd3, 16'd1, 1'b0);
    wait_done(17, 16);
    ack_i = 1'b1; start_i = 1'b1; dividend_i = 16'd20; divisor_i = 16'd4;
    @(negedge clk);
    ack_i = 1'b0; start_i = 1'b0;
    chk("ack_start_idle", {62'd0, busy_o, done_o}, 64'd0);
    @(negedge clk);
    chk("ack_start_still_idle", {62'd0, busy_o, done_o}, 64'd0);
    issue(16'd20, 16'd4, 16'd5, 16'd0, 1'b0);
    wait_done(17, 16);
    ack_and_check();

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
